pwm_driver: RTL and testbench
=============================

# pwm_driver

Motor PWM generator that sits between the PID controller and the H-bridge pins, the consuming end of the `pwm_update`/`pwm_ratio`/`pwm_direction`/`pwm_done` interface. It produces a fixed-period 256-step PWM waveform and takes new ratio/direction values only at period boundaries. It acknowledges each applied update with a one-cycle `pwm_done` pulse. Before any direction reversal it inserts a programmable dead interval with the output forced low.

## Interface
- `PRESCALE`, 16: clocks per PWM count step (≥1); PWM period = 256·PRESCALE clocks.
- `DIR_DEAD_PERIODS`, 2: full PWM periods of forced-low output before a direction reversal takes effect (≥1).
- `clock`  in  1  main clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pwm_enable`  in  1  level; low forces IDLE.
- `pwm_update`  in  1  level request; sampled only at period boundaries.
- `pwm_ratio`  in  8  requested high-time out of 256 counts.
- `pwm_direction`  in  1  requested motor direction.
- `pwm_done`  out  1  one-cycle pulse; new ratio/direction now active.
- `pwm_out`  out  1  PWM waveform to the bridge.
- `motor_dir`  out  1  applied direction to the bridge.
- `busy`  out  1  high while in DEAD.

## Operation
- Internal registers: prescaler `pre` (0..PRESCALE-1), period counter `cnt` (8 bit), `active_ratio` (8), `pend_ratio` (8), `pend_dir` (1), dead counter (sized for DIR_DEAD_PERIODS).
- tick = (`pre` == PRESCALE-1). On each tick `pre` returns to 0 and `cnt` increments (wrapping 255→0). Otherwise `pre` increments. With PRESCALE=1 every clock is a tick.
- boundary = tick && `cnt` == 255, evaluated only in RUN/DEAD.
- `pwm_out` <= (`cnt` < `active_ratio`), registered every clock. Ratio 0 gives constant low; 255 gives high for 255 of 256 counts.
- States:
  - IDLE: `pre` = PRESCALE-1, `cnt` = 255, `active_ratio` = 0, `pwm_out` = 0, `motor_dir` held. Goes to RUN when `pwm_enable` is high.
  - RUN: at a boundary with `pwm_update` high:
    - If `pwm_direction` == `motor_dir` or `active_ratio` == 0: load `active_ratio` = `pwm_ratio` and `motor_dir` = `pwm_direction`, pulse `pwm_done`.
    - Otherwise: capture `pend_ratio`/`pend_dir`, set `active_ratio` = 0, dead counter = DIR_DEAD_PERIODS, go to DEAD. No `pwm_done` pulse.
  - DEAD: `busy` = 1. At each boundary, the dead counter decrements, and if `pwm_update` is high the pending values are re-captured (latest wins). On the boundary where the counter reaches 0, load `motor_dir` = `pend_dir` and `active_ratio` = `pend_ratio`, pulse `pwm_done`, and return to RUN. The dead interval completes even if the pending direction reverts to `motor_dir`.
- `pwm_enable` low in any state: next cycle is IDLE and the pending request is discarded. This has priority over all boundary actions.
- `pwm_update` low at a boundary: no change and no `pwm_done`.

## Timing
- Reset values: `pwm_out` 0, `motor_dir` 0, `pwm_done` 0, `busy` 0, state IDLE, `pre` PRESCALE-1, `cnt` 255, ratios 0.
- The first RUN cycle after enable is a boundary, so an update present at enable is applied in that cycle. `pwm_done` is asserted that cycle and `cnt` = 0.
- `pwm_done` is asserted in the same cycle `active_ratio`/`motor_dir` change. `pwm_out` reflects the new ratio one clock later.
- Steady state: at most one `pwm_done` per 256·PRESCALE clocks.
- Reversal latency from the requesting boundary to `pwm_done` is exactly DIR_DEAD_PERIODS·256·PRESCALE clocks. `pwm_out` stays 0 throughout.
- `pwm_enable` falling mid-period truncates the pulse: `pwm_out` is 0 within 2 clocks.

## Structure
- Shared package holds the state encoding (IDLE 2'b00, RUN 2'b01, DEAD 2'b10) and PWM_CNT_MAX = 8'hFF.
- Sub-module `pwm_prescaler`: the `pre` counter with a synchronous load-to-max input (driven in IDLE) and a `tick` output.

## Test plan
- PRESCALE=2, enable with `pwm_update`=1 and ratio 8'd64 → `pwm_done` on the first RUN cycle. Each 512-clock period then has exactly 128 high clocks.
- Ratio 0 and ratio 255 → `pwm_out` constantly 0; and high for 510 of every 512 clocks, respectively.
- Running at ratio 100, dir 0, request ratio 80 with dir 1 → `busy` for 1024 clocks with `pwm_out` 0. Then `motor_dir`=1, `pwm_done` pulses, and 160 high clocks per period.
- At `active_ratio` 0, request a direction flip with ratio 50 → applied at the next boundary, with no DEAD state.
- Drop `pwm_enable` mid-high-pulse, and separately during DEAD → `pwm_out` 0 within 2 clocks, state IDLE, no `pwm_done`. Re-enable applies a fresh request immediately.
- Assert `reset_n` mid-period → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pwm_driver_pkg.sv
// Shared definitions for the motor PWM driver: FSM encoding and count limits.
package pwm_driver_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDead = 2'b10
  } pwm_state_e;

  localparam logic [7:0] PWM_CNT_MAX = 8'hFF;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler for the PWM counter: counts 0..PRESCALE-1 and flags the last
// step as a tick. A synchronous load parks the counter at its maximum so the
// very first enabled cycle is a tick.
module pwm_prescaler #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_load_max,
  output logic o_tick
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  logic [PreW-1:0] r_pre;
  logic            w_tick;

  assign w_tick = (r_pre == PreMax);
  assign o_tick = w_tick;

  // Prescale counter: park at max while loading, wrap to 0 on tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= PreMax;
    end else if (i_load_max) begin
      r_pre <= PreMax;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_driver.sv
// Motor PWM driver: 256-step fixed-period PWM, ratio/direction updates taken
// only at period boundaries, and a forced-low dead interval before reversals.
module pwm_driver
  import pwm_driver_pkg::*;
#(
  parameter int unsigned PRESCALE         = 16,
  parameter int unsigned DIR_DEAD_PERIODS = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       motor_dir,
  output logic       busy
);

  localparam int unsigned DeadW = $clog2(DIR_DEAD_PERIODS + 1);
  localparam logic [DeadW-1:0] DeadLoad = DeadW'(DIR_DEAD_PERIODS);
  localparam logic [DeadW-1:0] DeadLast = DeadW'(1);

  pwm_state_e       r_state, w_state_d;
  logic [7:0]       r_cnt;
  logic [7:0]       r_active_ratio, w_active_ratio_d;
  logic [7:0]       r_pend_ratio, w_pend_ratio_d;
  logic             r_pend_dir, w_pend_dir_d;
  logic [DeadW-1:0] r_dead, w_dead_d;
  logic             r_motor_dir, w_motor_dir_d;
  logic             r_pwm_done, w_pwm_done_d;
  logic             r_pwm_out;

  logic             w_tick;
  logic             w_boundary;
  logic             w_load_max;
  logic [7:0]       w_sel_ratio;
  logic             w_sel_dir;

  // Counters sit at max whenever the next state is IDLE.
  assign w_load_max = (w_state_d == StIdle);

  pwm_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_load_max(w_load_max),
    .o_tick    (w_tick)
  );

  assign w_boundary = w_tick && (r_cnt == PWM_CNT_MAX);

  // In DEAD the newest request present at a boundary supersedes the pending one.
  assign w_sel_ratio = pwm_update ? pwm_ratio : r_pend_ratio;
  assign w_sel_dir   = pwm_update ? pwm_direction : r_pend_dir;

  // Next-state and update decisions; disable overrides every boundary action.
  always_comb begin
    w_state_d        = r_state;
    w_active_ratio_d = r_active_ratio;
    w_pend_ratio_d   = r_pend_ratio;
    w_pend_dir_d     = r_pend_dir;
    w_dead_d         = r_dead;
    w_motor_dir_d    = r_motor_dir;
    w_pwm_done_d     = 1'b0;

    if (!pwm_enable) begin
      w_state_d        = StIdle;
      w_active_ratio_d = '0;
      w_pend_ratio_d   = '0;
      w_pend_dir_d     = r_motor_dir;
      w_dead_d         = '0;
    end else begin
      unique case (r_state)
        // Counters are parked at max in IDLE, so the enabling edge is itself a
        // boundary; active ratio is 0 here, so any direction applies at once.
        StIdle: begin
          w_state_d = StRun;
          if (pwm_update) begin
            w_active_ratio_d = pwm_ratio;
            w_motor_dir_d    = pwm_direction;
            w_pwm_done_d     = 1'b1;
          end
        end
        StRun: begin
          if (w_boundary && pwm_update) begin
            if ((pwm_direction == r_motor_dir) || (r_active_ratio == 8'd0)) begin
              w_active_ratio_d = pwm_ratio;
              w_motor_dir_d    = pwm_direction;
              w_pwm_done_d     = 1'b1;
            end else begin
              w_pend_ratio_d   = pwm_ratio;
              w_pend_dir_d     = pwm_direction;
              w_active_ratio_d = '0;
              w_dead_d         = DeadLoad;
              w_state_d        = StDead;
            end
          end
        end
        StDead: begin
          if (w_boundary) begin
            w_pend_ratio_d = w_sel_ratio;
            w_pend_dir_d   = w_sel_dir;
            if (r_dead == DeadLast) begin
              w_dead_d         = '0;
              w_active_ratio_d = w_sel_ratio;
              w_motor_dir_d    = w_sel_dir;
              w_pwm_done_d     = 1'b1;
              w_state_d        = StRun;
            end else begin
              w_dead_d = r_dead - 1'b1;
            end
          end
        end
        default: begin
          w_state_d        = StIdle;
          w_active_ratio_d = '0;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StIdle;
      r_active_ratio <= '0;
      r_pend_ratio   <= '0;
      r_pend_dir     <= 1'b0;
      r_dead         <= '0;
      r_motor_dir    <= 1'b0;
      r_pwm_done     <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_active_ratio <= w_active_ratio_d;
      r_pend_ratio   <= w_pend_ratio_d;
      r_pend_dir     <= w_pend_dir_d;
      r_dead         <= w_dead_d;
      r_motor_dir    <= w_motor_dir_d;
      r_pwm_done     <= w_pwm_done_d;
    end
  end

  // Period counter: parked at 255 with the prescaler, advances once per tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= PWM_CNT_MAX;
    end else if (w_load_max) begin
      r_cnt <= PWM_CNT_MAX;
    end else if (w_tick) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Registered PWM compare; follows a ratio change one clock later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_out <= 1'b0;
    end else begin
      r_pwm_out <= (r_cnt < r_active_ratio);
    end
  end

  assign pwm_out   = r_pwm_out;
  assign motor_dir = r_motor_dir;
  assign pwm_done  = r_pwm_done;
  assign busy      = (r_state == StDead);

endmodule

// File: tb/tb_pwm_driver.sv
// Scoreboard bench for pwm_driver with PRESCALE=2 and DIR_DEAD_PERIODS=2.
module tb_pwm_driver;

  localparam int unsigned PRESCALE = 2;
  localparam int unsigned DEAD     = 2;
  localparam int PERIOD            = 256 * PRESCALE;

  logic       clock;
  logic       reset_n;
  logic       pwm_enable;
  logic       pwm_update;
  logic [7:0] pwm_ratio;
  logic       pwm_direction;
  logic       pwm_done;
  logic       pwm_out;
  logic       motor_dir;
  logic       busy;

  typedef struct packed {
    logic       dir;
    logic [7:0] ratio;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks;
  int   n_errors;

  pwm_driver #(
    .PRESCALE        (PRESCALE),
    .DIR_DEAD_PERIODS(DEAD)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pwm_enable   (pwm_enable),
    .pwm_update   (pwm_update),
    .pwm_ratio    (pwm_ratio),
    .pwm_direction(pwm_direction),
    .pwm_done     (pwm_done),
    .pwm_out      (pwm_out),
    .motor_dir    (motor_dir),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting, expected event", name);
  endtask

  // Queue the expected acknowledge and raise the update request.
  task automatic request(input logic [7:0] r, input logic d, input bit expect_done);
    pwm_ratio     = r;
    pwm_direction = d;
    pwm_update    = 1'b1;
    if (expect_done) sb_q.push_back('{dir: d, ratio: r});
  endtask

  task automatic wait_done(input string name, input int max_cyc, output int lat,
                           output bit saw_busy);
    lat      = 0;
    saw_busy = 1'b0;
    while (1) begin
      @(negedge clock);
      lat++;
      if (busy) saw_busy = 1'b1;
      if (pwm_done) return;
      if (lat >= max_cyc) begin
        timeout(name);
        return;
      end
    end
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clock);
      if (pwm_out) hi++;
    end
  endtask

  task automatic wait_high(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (pwm_out) return;
    end
    timeout(name);
  endtask

  // Monitor: every acknowledge must match the oldest queued request.
  always @(negedge clock) begin
    if (reset_n && pwm_done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL done_unexpected: pwm_done=1 with no request queued, expected 0");
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("done_dir_r%0d", mon_e.ratio), int'(motor_dir), int'(mon_e.dir));
        chk($sformatf("done_busy_r%0d", mon_e.ratio), int'(busy), 0);
      end
    end
  end

  initial begin
    int lat;
    int hi;
    int bcnt;
    int dead_hi;
    bit sb;
    bit got;

    n_checks      = 0;
    n_errors      = 0;
    reset_n       = 1'b0;
    pwm_enable    = 1'b0;
    pwm_update    = 1'b0;
    pwm_ratio     = 8'd0;
    pwm_direction = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_motor_dir", int'(motor_dir), 0);
    chk("rst_done", int'(pwm_done), 0);
    chk("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    count_high(20, hi);
    chk("idle_high", hi, 0);

    // Enable with a request present: acknowledged on the first RUN cycle.
    request(8'd64, 1'b0, 1'b1);
    pwm_enable = 1'b1;
    wait_done("en_done", 4, lat, sb);
    chk("en_done_lat", lat, 1);
    pwm_update = 1'b0;
    count_high(PERIOD, hi);
    chk("duty_64", hi, 128);

    request(8'd0, 1'b0, 1'b1);
    wait_done("r0_done", PERIOD + 4, lat, sb);
    pwm_update = 1'b0;
    count_high(PERIOD, hi);
    chk("duty_0", hi, 0);

    request(8'd255, 1'b0, 1'b1);
    wait_done("r255_done", PERIOD + 4, lat, sb);
    pwm_update = 1'b0;
    count_high(PERIOD, hi);
    chk("duty_255", hi, 510);

    request(8'd100, 1'b0, 1'b1);
    wait_done("r100_done", PERIOD + 4, lat, sb);
    chk("r100_no_dead", int'(sb), 0);
    pwm_update = 1'b0;
    count_high(PERIOD, hi);
    chk("duty_100", hi, 200);

    // Reversal at nonzero ratio: dead interval of two full periods.
    request(8'd80, 1'b1, 1'b1);
    bcnt    = 0;
    dead_hi = 0;
    got     = 1'b0;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      @(negedge clock);
      if (busy) begin
        bcnt++;
        if (pwm_out) dead_hi++;
      end
      if (pwm_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout("rev_done");
    chk("rev_busy_clocks", bcnt, DEAD * PERIOD);
    chk("rev_dead_high", dead_hi, 0);
    chk("rev_motor_dir", int'(motor_dir), 1);
    pwm_update = 1'b0;
    count_high(PERIOD, hi);
    chk("duty_80", hi, 160);

    // Flip at ratio 0 goes straight through without DEAD.
    request(8'd0, 1'b1, 1'b1);
    wait_done("z_done", PERIOD + 4, lat, sb);
    pwm_update = 1'b0;
    @(negedge clock);
    request(8'd50, 1'b0, 1'b1);
    wait_done("zflip_done", PERIOD + 4, lat, sb);
    chk("zflip_no_dead", int'(sb), 0);
    chk("zflip_dir", int'(motor_dir), 0);
    pwm_update = 1'b0;
    count_high(PERIOD, hi);
    chk("duty_50", hi, 100);

    // Disable in the middle of a high pulse.
    wait_high("mid_high", PERIOD + 4);
    repeat (10) @(negedge clock);
    chk("mid_high_pre", int'(pwm_out), 1);
    pwm_enable = 1'b0;
    repeat (2) @(negedge clock);
    chk("dis_pwm_out", int'(pwm_out), 0);
    chk("dis_busy", int'(busy), 0);
    count_high(PERIOD + 20, hi);
    chk("dis_idle_high", hi, 0);
    chk("dis_dir_held", int'(motor_dir), 0);

    // Re-enable with a reversal: ratio is 0 in IDLE so it applies at once.
    request(8'd64, 1'b1, 1'b1);
    pwm_enable = 1'b1;
    wait_done("reen_done", 4, lat, sb);
    chk("reen_lat", lat, 1);
    chk("reen_dir", int'(motor_dir), 1);
    pwm_update = 1'b0;

    // Disable during DEAD: the pending reversal is dropped.
    request(8'd30, 1'b0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < PERIOD + 8; i++) begin
      @(negedge clock);
      if (busy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout("dead_entry");
    repeat (100) @(negedge clock);
    chk("dead_mid_busy", int'(busy), 1);
    pwm_enable = 1'b0;
    pwm_update = 1'b0;
    repeat (2) @(negedge clock);
    chk("deaddis_busy", int'(busy), 0);
    chk("deaddis_pwm_out", int'(pwm_out), 0);
    chk("deaddis_dir", int'(motor_dir), 1);
    count_high(DEAD * PERIOD + 100, hi);
    chk("deaddis_high", hi, 0);

    request(8'd20, 1'b1, 1'b1);
    pwm_enable = 1'b1;
    wait_done("reen2_done", 4, lat, sb);
    chk("reen2_lat", lat, 1);
    pwm_update = 1'b0;

    // Asynchronous reset in mid-pulse.
    wait_high("rst_mid_high", PERIOD + 4);
    chk("rst_pre_out", int'(pwm_out), 1);
    chk("rst_pre_dir", int'(motor_dir), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pwm_out", int'(pwm_out), 0);
    chk("arst_motor_dir", int'(motor_dir), 0);
    chk("arst_done", int'(pwm_done), 0);
    chk("arst_busy", int'(busy), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    pwm_enable = 1'b0;
    repeat (3) @(negedge clock);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
